// File: rtl/lvdt_phase_capture.sv
// lvdt_phase_capture
// Read-side Avalon-MM slave for the LVDT oscillator phase/status lines.
// The 8-bit input bus is synchronized, and rising edges are latched per bit
// into a sticky capture register with write-1-to-clear semantics. Edges on
// bit 0, the oscillator reference, are also counted. A maskable level
// interrupt is raised from the captured edges.

module lvdt_phase_capture (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] address,
   input  logic       chipselect,
   input  logic       write_n,
   input  logic [7:0] writedata,
   input  logic [7:0] in_port,
   output logic [7:0] readdata,
   output logic       irq
);

   typedef enum logic [1:0] {
      ADDR_DATA  = 2'd0,
      ADDR_MASK  = 2'd1,
      ADDR_EDGE  = 2'd2,
      ADDR_COUNT = 2'd3
   } reg_addr_e;

   reg_addr_e  reg_sel;
   logic       wr_en;

   // Synchronizer chain; s3 is the previous value of s2 and is used for edge detection.
   logic [7:0] s1_q, s1_d;
   logic [7:0] s2_q, s2_d;
   logic [7:0] s3_q, s3_d;

   logic [7:0] mask_q, mask_d;
   logic [7:0] capt_q, capt_d;
   logic [7:0] count_q, count_d;
   logic [1:0] warm_q, warm_d;

   logic       armed;
   logic [7:0] rise;
   logic [7:0] clr;

   assign reg_sel = reg_addr_e'(address);
   assign wr_en   = chipselect && !write_n;

   // Next-state logic: synchronizer shift, warm-up, edge capture, mask and count.
   always_comb begin
      // NOTE: every _d gets a default before any branch, so no path can leave it unassigned and infer a latch.
      s1_d    = in_port;
      s2_d    = s1_q;
      s3_d    = s2_q;
      mask_d  = mask_q;
      count_d = count_q;
      clr     = 8'h00;

      // Edge detection stays off until s2/s3 hold values sampled after reset release.
      // Without this, a line already high at release would be seen as a false edge.
      warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      armed   = (warm_q == 2'd3);
      rise    = s2_q & ~s3_q & {8{armed}};

      if (wr_en) begin
         case (reg_sel)
            ADDR_MASK:  mask_d  = writedata;
            ADDR_EDGE:  clr     = writedata;
            ADDR_COUNT: count_d = 8'h00;
            default:    ;
         endcase
      end

      // A new edge wins over a same-cycle clear of the same bit.
      capt_d = (capt_q & ~clr) | rise;

      // A reference edge coinciding with a count clear is counted as the first edge after the clear.
      if (rise[0]) begin
         if (wr_en && (reg_sel == ADDR_COUNT)) begin
            count_d = 8'd1;
         end else begin
            count_d = count_q + 8'd1;
         end
      end
   end

   // State registers; asynchronous reset clears everything, including pending captures.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= 8'h00;
         s2_q    <= 8'h00;
         s3_q    <= 8'h00;
         mask_q  <= 8'h00;
         capt_q  <= 8'h00;
         count_q <= 8'h00;
         warm_q  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         mask_q  <= mask_d;
         capt_q  <= capt_d;
         count_q <= count_d;
         warm_q  <= warm_d;
      end
   end

   // Zero-wait-state read mux; it ignores chipselect, so it reads 0 everywhere while in reset.
   always_comb begin
      readdata = 8'h00;
      case (reg_sel)
         ADDR_DATA:  readdata = s2_q;
         ADDR_MASK:  readdata = mask_q;
         ADDR_EDGE:  readdata = capt_q;
         ADDR_COUNT: readdata = count_q;
         default:    readdata = 8'h00;
      endcase
   end

   assign irq = |(capt_q & mask_q);

endmodule

// File: tb/tb_lvdt_phase_capture.sv
// Directed testbench for lvdt_phase_capture.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled there as well.

module tb_lvdt_phase_capture;

   localparam logic [1:0] A_DATA  = 2'd0;
   localparam logic [1:0] A_MASK  = 2'd1;
   localparam logic [1:0] A_EDGE  = 2'd2;
   localparam logic [1:0] A_COUNT = 2'd3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] address;
   logic       chipselect;
   logic       write_n;
   logic [7:0] writedata;
   logic [7:0] in_port;
   logic [7:0] readdata;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   lvdt_phase_capture dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
      address = a;
      #1;
      check(tag, readdata, exp);
   endtask

   task automatic chk_irq(input logic exp, input string tag);
      check(tag, {7'd0, irq}, {7'd0, exp});
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // One period of the reference line: 2 clocks low, then 2 clocks high. Bit 2 stays high.
   task automatic ref_period();
      in_port = 8'h04;
      tick();
      tick();
      in_port = 8'h05;
      tick();
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = A_DATA;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 8'h00;
      in_port    = 8'hFF;

      // While in reset, every register reads 0 and irq is low.
      tick();
      tick();
      rd(A_DATA,  8'h00, "rst_data");
      rd(A_MASK,  8'h00, "rst_mask");
      rd(A_EDGE,  8'h00, "rst_edge");
      tick();
      rd(A_COUNT, 8'h00, "rst_count");
      chk_irq(1'b0, "rst_irq");

      // Release reset with all lines already high: no false edges, and DATA reads FF from cycle 2.
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i >= 2) rd(A_DATA, 8'hFF, $sformatf("warm_data_%0d", i));
         rd(A_EDGE,  8'h00, $sformatf("warm_edge_%0d", i));
         rd(A_COUNT, 8'h00, $sformatf("warm_count_%0d", i));
         chk_irq(1'b0, $sformatf("warm_irq_%0d", i));
      end

      // Falling lines do not capture anything.
      in_port = 8'h00;
      tick();
      tick();
      tick();
      rd(A_DATA, 8'h00, "fall_data");
      rd(A_EDGE, 8'h00, "fall_edge");

      // 00 -> 05: DATA updates 2 edges after the change, EDGE/COUNT update after 3.
      in_port = 8'h05;
      tick();
      tick();
      rd(A_DATA, 8'h05, "rise_data_k1");
      rd(A_EDGE, 8'h00, "rise_edge_k1");
      tick();
      rd(A_EDGE,  8'h05, "rise_edge_k2");
      rd(A_COUNT, 8'h01, "rise_count_k2");
      chk_irq(1'b0, "rise_irq_unmasked");
      tick();
      tick();
      rd(A_EDGE,  8'h05, "level_edge_hold");
      rd(A_COUNT, 8'h01, "level_count_once");

      // Writes to DATA are ignored.
      wr(A_DATA, 8'hAA);
      rd(A_DATA, 8'h05, "data_write_ignored");

      // Unmasking a captured bit raises irq on the edge after the write.
      wr(A_MASK, 8'h04);
      chk_irq(1'b1, "mask_sets_irq");
      rd(A_MASK, 8'h04, "mask_readback");

      // Write-1-to-clear on bit 2 drops irq and leaves bit 0 set.
      wr(A_EDGE, 8'h04);
      chk_irq(1'b0, "clear_drops_irq");
      rd(A_EDGE, 8'h01, "clear_edge_w1c");

      // A clear of bit 0 in the same cycle as a new rise on bit 0 leaves the bit set.
      in_port = 8'h04;
      tick();
      tick();
      tick();
      in_port = 8'h05;
      tick();
      tick();
      wr(A_EDGE, 8'h01);
      rd(A_EDGE,  8'h01, "edge_wins_clear");
      rd(A_COUNT, 8'h02, "edge_wins_count");
      chk_irq(1'b0, "edge_wins_irq");

      // A COUNT write in the same cycle as a rise on bit 0 loads 1.
      in_port = 8'h04;
      tick();
      tick();
      tick();
      in_port = 8'h05;
      tick();
      tick();
      wr(A_COUNT, 8'h00);
      rd(A_COUNT, 8'h01, "count_write_with_rise");

      // A COUNT write without a rise clears it to 0.
      wr(A_COUNT, 8'h5A);
      rd(A_COUNT, 8'h00, "count_write_clear");

      // 255 reference periods reach FF, then 2 more periods wrap to 01.
      for (int i = 0; i < 255; i++) ref_period();
      tick();
      tick();
      rd(A_COUNT, 8'hFF, "count_255");
      ref_period();
      ref_period();
      tick();
      tick();
      rd(A_COUNT, 8'h01, "count_wrap_257");
      rd(A_EDGE,  8'h01, "toggle_edge");

      // Raise irq, then assert reset between edges: state clears without waiting for a clock edge.
      wr(A_MASK, 8'h01);
      chk_irq(1'b1, "pre_reset_irq");
      reset_n = 1'b0;
      #1;
      chk_irq(1'b0, "async_reset_irq");
      rd(A_EDGE,  8'h00, "async_reset_edge");
      rd(A_MASK,  8'h00, "async_reset_mask");
      rd(A_COUNT, 8'h00, "async_reset_count");

      // Warm-up restarts: a line going high right after release is first captured at edge 4.
      in_port = 8'h00;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      in_port = 8'h01;
      tick();
      tick();
      rd(A_EDGE, 8'h00, "first_capture_edge3");
      tick();
      rd(A_EDGE,  8'h01, "first_capture_edge4");
      rd(A_COUNT, 8'h01, "first_capture_count");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lvdt_phase_capture.md
# lvdt_phase_capture

Avalon-MM read-side slave that returns the LVDT oscillator phase/status lines to the Nios processor. It is the input-direction counterpart of the write-only phase output register. It synchronizes an 8-bit external input bus and latches rising edges per bit into a sticky capture register. It raises a maskable interrupt and counts rising edges on bit 0, which is the oscillator reference. Zero-wait-state slave on the system bus.

## Interface
- No parameters; all widths fixed at 8 bits.
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  8  write data
- in_port  in  8  asynchronous external phase/status lines
- readdata  out  8  read data, combinational from address
- irq  out  1  level interrupt, active high

## Operation
- Register map:
  - addr 0 DATA: read returns the synchronized input s2. Writes are ignored.
  - addr 1 MASK: read/write, 8-bit interrupt mask.
  - addr 2 EDGE: read returns the sticky capture. Write is write-1-to-clear, per bit.
  - addr 3 COUNT: read returns the 8-bit rising-edge count on bit 0. Any write clears it.
- A write is `chipselect && !write_n`. Writes take effect on the clock edge.
- readdata is a pure mux of the register selected by address and does not depend on chipselect.
- Synchronizer: s1 <= in_port, then s2 <= s1, then s3 <= s2.
- Edge vector: rise = s2 & ~s3 & {8{armed}}.
- Warm-up counter:
  - 2-bit counter, 0 after reset, increments each cycle until it saturates at 3.
  - armed = (warm-up == 3).
  - Prevents false edges from inputs that are already high when reset is released.
- EDGE next state = (EDGE & ~clr) | rise.
  - clr = writedata when EDGE is written, else 0.
  - If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- COUNT next state:
  - COUNT is written and rise[0] = 1 in the same cycle: 1.
  - COUNT is written, no rise[0]: 0.
  - Otherwise, rise[0] = 1: COUNT + 1, modulo 256 (255 wraps to 0, no saturation, no flag).
- irq = |(EDGE & MASK), combinational from the registers.
  - Setting a MASK bit while the matching EDGE bit is already 1 asserts irq the cycle after the write edge.
  - Clearing MASK or EDGE deasserts irq the cycle after the write edge.
- Reset values: s1, s2, s3, MASK, EDGE, COUNT, warm-up all 0. irq = 0. readdata follows the mux, so it reads 0 at every address during reset.
- Reset asserted mid-operation clears all state immediately, including captured edges and any pending irq. Warm-up restarts on release.

## Timing
- in_port changes before clock edge k (with setup met):
  - s1 updates at edge k.
  - DATA readable after edge k+1.
  - EDGE bit set and COUNT incremented at edge k+2.
  - irq high after edge k+2 if the bit is masked in.
- A pulse on in_port must be held at least 2 clk periods to be captured reliably. Shorter pulses may be missed.
- A level held high produces exactly one rise cycle. Re-triggering requires a low of at least 2 clocks.
- First possible capture: at clock edge 4 after reset release.
- Read latency 0 (combinational readdata). Write latency 1 clock.

## Test plan
- Reset with in_port = 8'hFF held through release → EDGE = 0, COUNT = 0, irq = 0 for 10 cycles; DATA reads 8'hFF from cycle 2 on.
- After warm-up, drive in_port 00→05 for 4 clocks → DATA = 8'h05 two cycles after the change; EDGE = 8'h05 and COUNT = 1 three cycles after; irq stays 0 with MASK = 0.
- With EDGE = 8'h05, write MASK = 8'h04 → irq = 1 next cycle. Write EDGE = 8'h04 → irq = 0 next cycle and EDGE = 8'h01.
- Write EDGE = 8'h01 in the same cycle that rise[0] fires → EDGE[0] stays 1. Write COUNT in the same cycle that rise[0] fires → COUNT = 1.
- Toggle bit 0 high/low (4-clock period) 257 times from COUNT = 0 → COUNT = 1 (wrapped). One-cycle pulses are not required to count.
- Assert reset_n low mid-stream with irq = 1 → irq, EDGE, MASK, COUNT = 0 asynchronously, before the next clock edge.
